// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: debug > data > fetch, with a fetch starvation override,
// wrapping each access in a fixed-latency request/done handshake (IDLE -> ACCESS -> RESP).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [DATA_W-1:0] dt_wdata,
  output logic              dt_gnt,
  output logic              dt_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned N_REQ    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // grant bits: [0] fetch, [1] data, [2] debug
  logic [N_REQ-1:0]    gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [DATA_W-1:0]   rdata_q;

  logic                win_if;
  logic                win_dt;
  logic                win_dbg;
  logic                any_win;
  logic                fetch_boost;
  logic                lat_done;

  // Priority pick; only acted upon while IDLE
  always_comb begin
    win_if      = 1'b0;
    win_dt      = 1'b0;
    win_dbg     = 1'b0;
    fetch_boost = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
    if (dbg_req) begin
      win_dbg = 1'b1;
    end else if (dt_req && !fetch_boost) begin
      win_dt = 1'b1;
    end else if (if_req) begin
      win_if = 1'b1;
    end
  end

  assign any_win  = win_if | win_dt | win_dbg;
  assign lat_done = (lat_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_win) state_nxt = ACCESS;
      ACCESS:  if (lat_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state and grant
  always_comb begin
    busy      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_gnt    = gnt_q[0];
    dt_gnt    = gnt_q[1];
    dbg_gnt   = gnt_q[2];
    if_done   = 1'b0;
    dt_done   = 1'b0;
    dbg_done  = 1'b0;
    case (state)
      ACCESS: begin
        busy      = 1'b1;
        mem_read  = !we_q;
        mem_write = we_q;
      end
      RESP: begin
        busy     = 1'b1;
        if_done  = gnt_q[0];
        dt_done  = gnt_q[1];
        dbg_done = gnt_q[2];
      end
      default: begin
      end
    endcase
  end

  // Grant, operand latch, latency counter and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_win) begin
            gnt_q   <= {win_dbg, win_dt, win_if};
            lat_cnt <= LAT_W'(MEM_LAT - 1);
            if (win_dbg) begin
              addr_q  <= dbg_addr;
              we_q    <= dbg_we;
              wdata_q <= dbg_wdata;
            end else if (win_dt) begin
              addr_q  <= dt_addr;
              we_q    <= dt_we;
              wdata_q <= dt_wdata;
            end else begin
              addr_q <= if_addr;
              we_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (lat_done) begin
            if (!we_q) rdata_q <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          gnt_q <= '0;
        end
        default: begin
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating count of arbitrations fetch lost while requesting
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (win_if) begin
        starve_cnt <= '0;
      end else if (if_req && any_win && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single accesses, arbitration/starvation/reset
// sequences, a MEM_LAT=1 instance, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;
  localparam int IF_R  = 0;
  localparam int DT_R  = 1;
  localparam int DBG_R = 2;
  localparam int N_RAND = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_req, if_gnt, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic              dt_req, dt_we, dt_gnt, dt_done;
  logic [ADDR_W-1:0] dt_addr;
  logic [DATA_W-1:0] dt_wdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write, busy;

  logic              l1_if_req, l1_if_gnt, l1_if_done;
  logic [ADDR_W-1:0] l1_if_addr, l1_mem_addr;
  logic              l1_dt_gnt, l1_dt_done, l1_dbg_gnt, l1_dbg_done;
  logic [DATA_W-1:0] l1_rdata, l1_mem_wdata, l1_mem_rdata;
  logic              l1_mem_read, l1_mem_write, l1_busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_gnt(dt_gnt), .dt_done(dt_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_done(l1_if_done),
    .dt_req(1'b0), .dt_we(1'b0), .dt_addr('0), .dt_wdata('0),
    .dt_gnt(l1_dt_gnt), .dt_done(l1_dt_done),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr('0), .dbg_wdata('0),
    .dbg_gnt(l1_dbg_gnt), .dbg_done(l1_dbg_done),
    .rdata(l1_rdata), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  // Memory: unwritten locations read a fixed address pattern
  bit [DATA_W-1:0] wmem [8192];
  bit              wvld [8192];

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h4A;
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      wmem[mem_addr] <= mem_wdata;
      wvld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata    = wvld[mem_addr] ? wmem[mem_addr] : pattern(mem_addr);
  assign l1_mem_rdata = l1_mem_addr[7:0] + 8'h01;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] gnt_v();
    return {dbg_gnt, dt_gnt, if_gnt};
  endfunction

  function automatic logic [2:0] done_v();
    return {dbg_done, dt_done, if_done};
  endfunction

  task automatic set_req(input int who, input bit on, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (who)
      IF_R: begin if_req = on; if_addr = a; end
      DT_R: begin dt_req = on; dt_we = we; dt_addr = a; dt_wdata = d; end
      default: begin dbg_req = on; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    endcase
  endtask

  // One isolated access started in an IDLE cycle, checked cycle by cycle
  task automatic run_txn(input string tag, input int who, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] exp_rd);
    bit         we_eff;
    logic [2:0] oh;
    we_eff = (who == IF_R) ? 1'b0 : we;
    oh     = 3'(1 << who);
    set_req(who, 1'b1, we, a, d);
    for (int k = 1; k <= MEM_LAT; k++) begin
      step();
      chk({tag, "_acc_ctl"}, {busy, gnt_v(), done_v(), mem_read, mem_write},
          {1'b1, oh, 3'b000, !we_eff, we_eff});
      chk({tag, "_acc_addr"}, mem_addr, a);
      if (we_eff) chk({tag, "_acc_wdata"}, mem_wdata, d);
    end
    step();
    chk({tag, "_resp_ctl"}, {busy, gnt_v(), done_v(), mem_read, mem_write}, {1'b1, oh, oh, 2'b00});
    chk({tag, "_resp_rdata"}, rdata, exp_rd);
    step();
    set_req(who, 1'b0, 1'b0, '0, '0);
    chk({tag, "_idle_ctl"}, {busy, gnt_v(), done_v(), mem_read, mem_write}, '0);
    chk({tag, "_idle_rdata"}, rdata, exp_rd);
  endtask

  typedef struct {
    int                who;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t              vecs [8];
  int                order [$];
  bit                drop [3];
  logic [ADDR_W-1:0] a_addr [3];
  int                exp3 [3] = '{DBG_R, DT_R, IF_R};
  int                exp8 [8] = '{DT_R, DT_R, DT_R, IF_R, DT_R, DT_R, DT_R, IF_R};
  logic [2:0]        dv;

  // Randomized-phase reference model state
  bit [DATA_W-1:0]   rmem [8192];
  bit                rvld [8192];
  bit                pend [3];
  bit                done_prev [3];
  logic [ADDR_W-1:0] op_addr [3];
  bit                op_we [3];
  logic [DATA_W-1:0] op_wd [3];
  int                prob [3] = '{40, 50, 10};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, who_m, starve, k, w, ndone, dut_dones;
    bit we_m, in_acc, in_resp;
    logic [ADDR_W-1:0] addr_m, ra;
    logic [DATA_W-1:0] wd_m, data_m, exp_rd, rd;
    logic [2:0] oh, eg, ed;

    vecs[0] = '{IF_R,  1'b0, 13'h0010, 8'h00, 8'h5A};
    vecs[1] = '{DT_R,  1'b1, 13'h1F00, 8'hC3, 8'h5A};
    vecs[2] = '{DBG_R, 1'b0, 13'h1F00, 8'h00, 8'hC3};
    vecs[3] = '{DT_R,  1'b0, 13'h0123, 8'h00, 8'h69};
    vecs[4] = '{DBG_R, 1'b1, 13'h0040, 8'h11, 8'h69};
    vecs[5] = '{IF_R,  1'b0, 13'h0040, 8'h00, 8'h11};
    vecs[6] = '{IF_R,  1'b1, 13'h0041, 8'hEE, 8'h0B};
    vecs[7] = '{DT_R,  1'b0, 13'h1FFF, 8'h00, 8'hB5};

    rst = 1'b1;
    set_req(IF_R, 1'b0, 1'b0, '0, '0);
    set_req(DT_R, 1'b0, 1'b0, '0, '0);
    set_req(DBG_R, 1'b0, 1'b0, '0, '0);
    l1_if_req = 1'b0;
    l1_if_addr = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_state", {busy, gnt_v(), done_v(), mem_read, mem_write, mem_addr, rdata}, '0);
    chk("reset_wdata", mem_wdata, '0);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].who, vecs[i].we, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata);
    end

    // All three request in the same IDLE cycle
    a_addr[IF_R] = 13'h0022; a_addr[DT_R] = 13'h0021; a_addr[DBG_R] = 13'h0020;
    for (int r = 0; r < 3; r++) begin
      set_req(r, 1'b1, 1'b0, a_addr[r], '0);
      drop[r] = 1'b0;
    end
    order.delete();
    for (int c = 0; c < 40; c++) begin
      step();
      for (int r = 0; r < 3; r++) begin
        if (drop[r]) begin set_req(r, 1'b0, 1'b0, '0, '0); drop[r] = 1'b0; end
      end
      chk("arb3_onehot", 32'($countones(gnt_v()) <= 1), 32'd1);
      dv = done_v();
      for (int r = 0; r < 3; r++) begin
        if (dv[r]) begin
          order.push_back(r);
          drop[r] = 1'b1;
          chk($sformatf("arb3_rdata_r%0d", r), rdata, pattern(a_addr[r]));
        end
      end
      if (order.size() == 3 && !busy && !(drop[0] | drop[1] | drop[2])) break;
    end
    chk("arb3_count", order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arb3_order%0d", i), (i < order.size()) ? order[i] : 99, exp3[i]);
    end

    // Fetch and data held continuously: starvation override
    set_req(DT_R, 1'b1, 1'b0, 13'h0030, '0);
    set_req(IF_R, 1'b1, 1'b0, 13'h0031, '0);
    order.delete();
    for (int c = 0; c < 80; c++) begin
      step();
      chk("starve_onehot", 32'($countones(gnt_v()) <= 1), 32'd1);
      dv = done_v();
      if (dv[DT_R]) order.push_back(DT_R);
      if (dv[IF_R]) order.push_back(IF_R);
      if (order.size() == 8) break;
    end
    step();
    set_req(DT_R, 1'b0, 1'b0, '0, '0);
    set_req(IF_R, 1'b0, 1'b0, '0, '0);
    step();
    chk("starve_idle", {busy, gnt_v()}, '0);
    chk("starve_count", order.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("starve_order%0d", i), (i < order.size()) ? order[i] : 99, exp8[i]);
    end

    // Reset in the second ACCESS cycle of a read
    set_req(IF_R, 1'b1, 1'b0, 13'h0010, '0);
    step();
    step();
    chk("rst_pre_access", {busy, mem_read}, 2'b11);
    rst = 1'b1;
    set_req(IF_R, 1'b0, 1'b0, '0, '0);
    step();
    rst = 1'b0;
    chk("rst_outputs", {busy, gnt_v(), done_v(), mem_read, mem_write, mem_addr, rdata}, '0);
    chk("rst_wdata", mem_wdata, '0);
    step();
    chk("rst_no_done", {busy, gnt_v(), done_v()}, '0);
    run_txn("post_rst", IF_R, 1'b0, 13'h0010, '0, 8'h5A);

    // MEM_LAT=1 instance: three-cycle occupancy
    l1_if_addr = 13'h0055;
    l1_if_req  = 1'b1;
    step();
    chk("lat1_c1", {l1_busy, l1_mem_read, l1_mem_write, l1_if_gnt, l1_if_done}, 5'b11010);
    chk("lat1_addr", l1_mem_addr, 13'h0055);
    step();
    chk("lat1_c2", {l1_busy, l1_mem_read, l1_mem_write, l1_if_gnt, l1_if_done}, 5'b10011);
    chk("lat1_rdata", l1_rdata, 8'h56);
    step();
    l1_if_req = 1'b0;
    chk("lat1_c3", {l1_busy, l1_if_gnt, l1_if_done}, 3'b000);

    // Randomized traffic against a transaction-level model
    set_req(IF_R, 1'b0, 1'b0, '0, '0);
    set_req(DT_R, 1'b0, 1'b0, '0, '0);
    set_req(DBG_R, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s = -1000; who_m = IF_R; we_m = 1'b0; addr_m = '0; wd_m = '0; data_m = '0;
    exp_rd = '0; starve = 0; ndone = 0; dut_dones = 0;
    for (int r = 0; r < 3; r++) begin pend[r] = 1'b0; done_prev[r] = 1'b0; end

    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (done_prev[r]) begin
          pend[r] = 1'b0;
          set_req(r, 1'b0, 1'b0, '0, '0);
        end else if (!pend[r] && ($urandom_range(0, 99) < prob[r])) begin
          pend[r]    = 1'b1;
          op_addr[r] = 13'($urandom_range(0, 63));
          op_we[r]   = (r != IF_R) && ($urandom_range(0, 1) == 1);
          op_wd[r]   = 8'($urandom);
          set_req(r, 1'b1, op_we[r], op_addr[r], op_wd[r]);
        end
      end

      k       = cyc - s;
      in_acc  = (k >= 1) && (k <= MEM_LAT);
      in_resp = (k == MEM_LAT + 1);
      if (in_resp && !we_m) exp_rd = data_m;
      oh = 3'(1 << who_m);
      eg = (in_acc || in_resp) ? oh : 3'b000;
      ed = in_resp ? oh : 3'b000;
      chk($sformatf("rand_cyc%0d", cyc),
          {busy, gnt_v(), done_v(), mem_read, mem_write, mem_addr, rdata},
          {in_acc || in_resp, eg, ed, in_acc && !we_m, in_acc && we_m, addr_m, exp_rd});
      if (in_acc && we_m) chk($sformatf("rand_wdata%0d", cyc), mem_wdata, wd_m);
      dut_dones += $countones(done_v());
      for (int r = 0; r < 3; r++) done_prev[r] = in_resp && (who_m == r);
      if (in_resp) ndone++;

      if ((k >= MEM_LAT + 2) && (pend[0] | pend[1] | pend[2])) begin
        if (pend[DBG_R]) w = DBG_R;
        else if (pend[DT_R] && !(pend[IF_R] && starve == STARVE_MAX)) w = DT_R;
        else w = IF_R;
        if (w == IF_R) starve = 0;
        else if (pend[IF_R] && starve < STARVE_MAX) starve++;
        s = cyc; who_m = w;
        addr_m = op_addr[w]; we_m = op_we[w]; wd_m = op_wd[w];
        ra = addr_m;
        if (we_m) begin
          rmem[ra] = wd_m;
          rvld[ra] = 1'b1;
        end else begin
          rd = rvld[ra] ? rmem[ra] : pattern(ra);
          data_m = rd;
        end
      end
      step();
    end
    chk("rand_done_total", dut_dones, ndone);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port instruction/data memory among three requesters: the controller's instruction fetch, the controller's data access, and a debug/loader port. It wraps every access in a fixed-latency request/done handshake. It sits between the multicycle controller/datapath and the memory, and replaces the direct PC/TR address muxing into memory. Debug has the highest priority, and a starvation guard keeps data traffic from blocking fetch indefinitely.

## Interface
- ADDR_W, 13, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 2, memory access latency in cycles (≥1)
- STARVE_MAX, 3, consecutive lost arbitrations after which fetch outranks data (≥1)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request (always a read)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch owns the memory (ACCESS and RESP)
- if_done  out  1  one-cycle completion pulse to fetch
- dt_req, dt_we  in  1 each  data request, and write-enable for that request
- dt_addr  in  ADDR_W  data address
- dt_wdata  in  DATA_W  data write value
- dt_gnt, dt_done  out  1 each  same meaning as the if_ signals, for data
- dbg_req, dbg_we  in  1 each  debug request and write-enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write value
- dbg_gnt, dbg_done  out  1 each  same meaning, for debug
- rdata  out  DATA_W  read result shared by all requesters; valid when the matching done is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read, mem_write  out  1 each  memory strobes
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP. Arbitration happens only in IDLE; requests arriving in ACCESS or RESP wait.
- IDLE priority:
  - Debug first.
  - Then data, unless starve_cnt == STARVE_MAX and if_req is high, in which case fetch wins.
  - Otherwise fetch.
- On a win, the arbiter registers the grant one-hot, plus addr, we (forced 0 for fetch) and wdata. It then moves to ACCESS with lat_cnt = MEM_LAT-1.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_read = !we and mem_write = we, both held for all MEM_LAT cycles.
  - lat_cnt decrements each cycle; at lat_cnt == 0 the state moves to RESP.
  - On a read, mem_rdata is captured into rdata at that same edge.
- RESP: the granted requester's done = 1 for exactly one cycle, then the state returns to IDLE. Grant clears on leaving RESP.
- rdata holds its last value after writes and idle cycles.
- Starvation counter (width clog2(STARVE_MAX+1), saturating):
  - Increments on each IDLE decision where if_req = 1 and fetch loses.
  - Clears on a fetch grant.
  - Unchanged otherwise.
  - The override never beats debug.
- Requester rule: hold req and its operands stable from assertion until done. Deassert on the edge that ends the done cycle. A req still high in the following IDLE cycle is a new request.
- Outside ACCESS: mem_read = mem_write = 0, and mem_addr/mem_wdata hold their latched values.
- Reset (any state, including mid-ACCESS):
  - Next cycle is IDLE.
  - All gnt/done/mem_read/mem_write/busy = 0; rdata, mem_addr, mem_wdata, starve_cnt and lat_cnt = 0.
  - The aborted access produces no done pulse.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from req to memory strobes.
- Request high in IDLE cycle 0 → ACCESS in cycles 1..MEM_LAT → done in cycle MEM_LAT+1 → IDLE in cycle MEM_LAT+2.
- Per-access occupancy is MEM_LAT+2 cycles. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Simultaneous requests: exactly one grant, decided in a single IDLE cycle. Losers stay pending and are reconsidered at the next IDLE.

## Test plan
- MEM_LAT=2, if_req with if_addr=0x0010, memory holds 0x5A → mem_read is high in cycles 1-2 with mem_addr=0x0010; if_done=1 and rdata=0x5A in cycle 3; busy is low in cycle 4.
- dt_req write (dt_addr=0x1F00, dt_wdata=0xC3) → mem_write high for 2 cycles with the latched values, mem_read stays 0, dt_done in cycle 3, rdata unchanged; a later debug read of 0x1F00 returns 0xC3.
- All three req high in the same IDLE cycle → dbg granted first, then dt, then if; exactly one gnt high at any time and one done per request.
- STARVE_MAX=3, if_req and dt_req held continuously → dt wins 3 times, then if is granted; starve_cnt returns to 0, after which dt wins again.
- rst asserted in the second ACCESS cycle of a read → next cycle is IDLE with all outputs 0; no done pulse; a request after reset completes normally.
- MEM_LAT=1 → occupancy is 3 cycles; done in cycle 2.
